// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: keeps a circular sample history and a coefficient bank, and
// steps an external single-cycle MAC ALU through one tap per cycle to form each output.
module fir_mac_sequencer #(
  parameter int NTAPS  = 8,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 39,
  parameter int AW     = $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] x_in,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [DATA_W-1:0] coef_data,
  output logic [ACC_W-1:0]  y_out,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              busy,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_b,
  output logic [ACC_W-1:0]  alu_sum_in,
  input  logic [ACC_W-1:0]  alu_sum_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_coef [NTAPS];
  logic [DATA_W-1:0] r_hist [NTAPS];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_newest;
  logic [AW-1:0]     r_k;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_y_out;
  logic              r_y_valid;

  logic              w_accept;
  logic              w_coef_wr;
  logic              w_last;
  logic [AW-1:0]     w_rd_idx;

  assign x_ready    = (r_state == ST_IDLE) && rst_n;
  assign w_accept   = x_valid && x_ready;
  // Writes are dropped while a result is in flight so it sees one coherent coefficient set.
  assign w_coef_wr  = coef_we && (r_state != ST_MAC);
  assign w_last     = (r_k == AW'(NTAPS - 1));
  // NTAPS is a power of two, so the AW-bit subtraction wraps around the delay line.
  assign w_rd_idx   = r_newest - r_k;

  assign busy       = (r_state == ST_MAC);
  assign alu_x      = busy ? r_hist[w_rd_idx] : '0;
  assign alu_b      = busy ? r_coef[r_k] : '0;
  assign alu_sum_in = r_acc;
  assign y_out      = r_y_out;
  assign y_valid    = r_y_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_coef[i] <= '0;
        r_hist[i] <= '0;
      end
    end else begin
      if (w_coef_wr) r_coef[coef_addr] <= coef_data;
      if (w_accept)  r_hist[r_wr_ptr]  <= x_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_wr_ptr  <= '0;
      r_newest  <= '0;
      r_k       <= '0;
      r_acc     <= '0;
      r_y_out   <= '0;
      r_y_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_acc    <= '0;
            r_k      <= '0;
            r_newest <= r_wr_ptr;
            r_state  <= ST_MAC;
          end
        end
        ST_MAC: begin
          r_acc <= alu_sum_out;
          r_k   <= r_k + 1'b1;
          if (w_last) begin
            r_y_out   <= alu_sum_out;
            r_y_valid <= 1'b1;
            r_wr_ptr  <= r_newest + 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (y_ready) begin
            r_y_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: behavioural ALU, direct-form FIR reference model and a
// scoreboard monitor that checks every output handshake, its latency and its stability.
module tb_fir_mac_sequencer;
  localparam int NTAPS  = 4;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 39;
  localparam int AW     = 2;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] x_in;
  logic              x_valid;
  logic              x_ready;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [DATA_W-1:0] coef_data;
  logic [ACC_W-1:0]  y_out;
  logic              y_valid;
  logic              y_ready;
  logic              busy;
  logic [DATA_W-1:0] alu_x;
  logic [DATA_W-1:0] alu_b;
  logic [ACC_W-1:0]  alu_sum_in;
  logic [ACC_W-1:0]  alu_sum_out;
  logic signed [31:0] w_prod;

  logic bp_mode;
  logic rdy_force;
  logic rnd_rdy;

  fir_mac_sequencer #(
    .NTAPS (NTAPS),
    .DATA_W(DATA_W),
    .ACC_W (ACC_W),
    .AW    (AW)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x_in       (x_in),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .y_out      (y_out),
    .y_valid    (y_valid),
    .y_ready    (y_ready),
    .busy       (busy),
    .alu_x      (alu_x),
    .alu_b      (alu_b),
    .alu_sum_in (alu_sum_in),
    .alu_sum_out(alu_sum_out)
  );

  // The external MAC ALU: wrapping 39-bit accumulate of a signed 16x16 product.
  assign w_prod      = $signed(alu_x) * $signed(alu_b);
  assign alu_sum_out = alu_sum_in + {{(ACC_W - 32){w_prod[31]}}, w_prod};
  assign y_ready     = bp_mode ? rnd_rdy : rdy_force;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;
  int          last_acc = -1000;
  logic        prev_yv  = 1'b0;
  logic [ACC_W-1:0] held_y;

  longint coef_m [NTAPS];
  longint hist_m [$];
  logic [ACC_W-1:0] exp_y [$];
  int exp_edge [$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    rnd_rdy <= ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_assert++;
    n_fail++;
    $display("FAIL %s at cycle %0d: got nothing, expected an event", nm, cyc);
  endtask

  function automatic logic [ACC_W-1:0] model_y();
    longint s;
    logic [63:0] u;
    s = 0;
    for (int k = 0; k < NTAPS; k++)
      if (k < hist_m.size()) s += coef_m[k] * hist_m[k];
    u = s;
    return u[ACC_W-1:0];
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", {63'b0, busy}, {63'b0, (cyc >= last_acc) && (cyc < last_acc + NTAPS)});
      if (x_valid && x_ready) begin
        hist_m.push_front(longint'($signed(x_in)));
        if (hist_m.size() > NTAPS) void'(hist_m.pop_back());
        exp_y.push_back(model_y());
        exp_edge.push_back(cyc + 1 + NTAPS);
        last_acc = cyc + 1;
      end
      if (y_valid && !prev_yv) begin
        if (exp_edge.size() == 0) fail_now("spurious_y_valid");
        else chk("latency", 64'(cyc), 64'(exp_edge.pop_front()));
        held_y = y_out;
      end else if (y_valid) begin
        chk("y_out_hold", 64'(y_out), 64'(held_y));
      end
      if (y_valid) chk("x_ready_in_done", {63'b0, x_ready}, 64'd0);
      if (y_valid && y_ready) begin
        if (exp_y.size() == 0) fail_now("unexpected_output");
        else chk("y_out", 64'(y_out), 64'(exp_y.pop_front()));
      end
      prev_yv = y_valid;
    end else begin
      prev_yv = 1'b0;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    x_valid = 1'b0;
    while (n < 300) begin
      @(negedge clk);
      if (x_ready) break;
      n++;
    end
    if (n >= 300) fail_now("wait_idle_timeout");
  endtask

  task automatic send(input logic [15:0] x, input logic we, input logic [AW-1:0] a,
                      input logic [15:0] d);
    wait_idle();
    @(posedge clk); #1;
    x_in = x;
    x_valid = 1'b1;
    if (we) begin
      coef_we = 1'b1;
      coef_addr = a;
      coef_data = d;
      coef_m[a] = longint'($signed(d));
    end
    @(posedge clk); #1;
    x_valid = 1'b0;
    coef_we = 1'b0;
  endtask

  task automatic wr_idle(input logic [AW-1:0] a, input logic [15:0] d);
    wait_idle();
    @(posedge clk); #1;
    coef_we = 1'b1;
    coef_addr = a;
    coef_data = d;
    coef_m[a] = longint'($signed(d));
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  // Write issued while the sequencer is busy; the model keeps the old coefficient.
  task automatic wr_raw(input logic [AW-1:0] a, input logic [15:0] d);
    coef_we = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_y.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_y.size() != 0) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  task automatic wait_y_valid();
    int n;
    n = 0;
    while (!y_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!y_valid) fail_now("y_valid_timeout");
  endtask

  task automatic do_reset();
    x_valid = 1'b0;
    coef_we = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_y_valid", {63'b0, y_valid}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_x_ready", {63'b0, x_ready}, 64'd0);
    chk("rst_y_out", 64'(y_out), 64'd0);
    hist_m.delete();
    exp_y.delete();
    exp_edge.delete();
    for (int i = 0; i < NTAPS; i++) coef_m[i] = 0;
    last_acc = -1000;
    repeat (3) @(posedge clk);
    chk("rst_hold_y_valid", {63'b0, y_valid}, 64'd0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_x_ready", {63'b0, x_ready}, 64'd1);
  endtask

  initial begin
    rst_n = 1'b1;
    x_in = '0;
    x_valid = 1'b0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    bp_mode = 1'b0;
    rdy_force = 1'b1;
    for (int i = 0; i < NTAPS; i++) coef_m[i] = 0;
    @(posedge clk); #1;
    do_reset();

    // Impulse response.
    for (int i = 0; i < NTAPS; i++) wr_idle(AW'(i), 16'(i + 1));
    send(16'd1, 1'b0, '0, '0);
    repeat (4) send(16'd0, 1'b0, '0, '0);
    drain();

    // Extreme negative operands.
    for (int i = 0; i < NTAPS; i++) wr_idle(AW'(i), 16'h8000);
    repeat (4) send(16'h8000, 1'b0, '0, '0);
    drain();

    // Coefficient write during MAC is dropped.
    send(16'd1, 1'b0, '0, '0);
    wr_raw('0, 16'd7);
    send(16'd2, 1'b0, '0, '0);
    drain();

    // Backpressure with a pending, changing sample.
    rdy_force = 1'b0;
    send(16'd5, 1'b0, '0, '0);
    x_valid = 1'b1;
    x_in = 16'($urandom);
    wait_y_valid();
    repeat (6) begin
      @(posedge clk); #1;
      x_in = 16'($urandom);
    end
    rdy_force = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_accept_next", {63'b0, x_ready}, 64'd1);
    @(posedge clk); #1;
    x_valid = 1'b0;
    drain();

    // Reset while the output is waiting in DONE.
    rdy_force = 1'b0;
    send(16'd3, 1'b0, '0, '0);
    wait_y_valid();
    @(posedge clk); #1;
    do_reset();
    rdy_force = 1'b1;

    // Coefficient write on the same edge as the sample.
    send(16'd1, 1'b1, '0, 16'd7);
    drain();

    // Reset mid-MAC, then a fresh impulse.
    do_reset();
    for (int i = 0; i < NTAPS; i++) wr_idle(AW'(i), 16'(i + 1));
    send(16'd1, 1'b0, '0, '0);
    send(16'd0, 1'b0, '0, '0);
    drain();
    send(16'd0, 1'b0, '0, '0);
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < NTAPS; i++) wr_idle(AW'(i), 16'(i + 1));
    send(16'd1, 1'b0, '0, '0);
    repeat (3) send(16'd0, 1'b0, '0, '0);
    drain();

    // Randomised traffic with output backpressure and stray coefficient writes.
    bp_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(16'($urandom), ($urandom_range(0, 1) == 1), AW'($urandom_range(0, NTAPS - 1)),
           16'($urandom));
      if ($urandom_range(0, 3) == 0) wr_raw(AW'($urandom_range(0, NTAPS - 1)), 16'($urandom));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog at cycle %0d: got no end of test, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed FIR filter controller built around the single-cycle signed MAC ALU (16x16 multiply plus 39-bit accumulate, combinational). It accepts one 16-bit sample per handshake and stores it in a circular delay line holding the last NTAPS samples. It then drives the external ALU for NTAPS consecutive cycles, one tap per cycle, and presents the 39-bit filter output over a valid/ready handshake. Coefficients are loaded through a simple write port.

## Interface
- NTAPS, 8, number of taps; power of two, at least 2
- DATA_W, 16, sample and coefficient width, signed
- ACC_W, 39, accumulator and output width, signed
- AW, $clog2(NTAPS), tap index width (derived)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- x_in  in  DATA_W  input sample, signed
- x_valid  in  1  sample valid
- x_ready  out  1  sample accepted when x_valid && x_ready at a clk edge
- coef_we  in  1  coefficient write strobe
- coef_addr  in  AW  tap index k
- coef_data  in  DATA_W  coefficient c[k], signed
- y_out  out  ACC_W  filter output, signed
- y_valid  out  1  output valid
- y_ready  in  1  output consumed when y_valid && y_ready
- busy  out  1  high in MAC state
- alu_x  out  DATA_W  ALU sample operand
- alu_b  out  DATA_W  ALU coefficient operand
- alu_sum_in  out  ACC_W  ALU accumulator input
- alu_sum_out  in  ACC_W  ALU result, equal to alu_sum_in + alu_x*alu_b

## Operation
- Output definition: y[n] = sum over k = 0..NTAPS-1 of c[k]*x[n-k].
- Arithmetic wraps modulo 2^ACC_W, which is the ALU's behaviour. The sequencer never saturates.
- Storage:
  - coef[0..NTAPS-1]
  - hist[0..NTAPS-1], a circular buffer
  - wr_ptr (AW bits), tap counter k (AW bits)
  - acc (ACC_W bits)
- States:
  - IDLE
    - x_ready = 1.
    - On an accepted sample: hist[wr_ptr] <= x_in, acc <= 0, k <= 0, latch newest = wr_ptr, go to MAC.
  - MAC
    - busy = 1.
    - ALU drive: alu_x = hist[(newest - k) mod NTAPS], alu_b = coef[k], alu_sum_in = acc.
    - Each edge: acc <= alu_sum_out, k <= k+1.
    - On the edge where k == NTAPS-1: y_out <= alu_sum_out, y_valid <= 1, wr_ptr <= newest+1 (mod NTAPS), go to DONE.
  - DONE
    - y_valid = 1, y_out held stable.
    - On y_ready: y_valid <= 0, go to IDLE.
- x_ready is combinational: (state == IDLE) && rst_n. It is 0 in MAC and DONE, and x_valid is ignored there.
- Outside MAC, the ALU ports drive alu_x = 0, alu_b = 0, alu_sum_in = acc.
- Coefficient writes:
  - Applied in IDLE and DONE.
  - Ignored (dropped) in MAC, so the in-flight result uses one coherent coefficient set.
- Simultaneous coef_we and sample accept in IDLE: both commit on the same edge, and the new coefficient is used for that sample.

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE; all coef, all hist, wr_ptr, k and acc = 0.
  - y_out = 0, y_valid = 0, busy = 0, x_ready = 0 while rst_n is low.
- Latency: sample accepted at edge E0 → y_valid high after edge E0+NTAPS. That is, the MAC cycles sit between E0 and E0+NTAPS.
- Minimum sample period is NTAPS+2 cycles: 1 IDLE + NTAPS MAC + 1 DONE, with y_ready held high.
- y_out and y_valid are registered. They are stable for as long as y_ready stays low.
- wr_ptr advances only on MAC completion, wrapping NTAPS-1 → 0. Zero-initialised history models zero pre-history.
- Reset asserted mid-MAC or mid-DONE:
  - The partial result is discarded and y_valid drops immediately.
  - The history is cleared. The first post-reset output equals that of a fresh filter.

## Test plan
- Reset: hold rst_n low 3 cycles → y_valid=0, y_out=0, busy=0, x_ready=0. After release → x_ready=1.
- Impulse (NTAPS=4): load coef {1,2,3,4}, feed samples 1,0,0,0,0 → outputs 1,2,3,4,0, each exactly 4 cycles after its accept edge.
- Extreme negatives (NTAPS=4): all coef = -32768, feed four samples of -32768 → outputs 2^30, 2^31, 3*2^30, 2^32 (4294967296). No sign-extension error.
- Backpressure: hold y_ready=0 for 6 cycles after y_valid with x_valid high and x_in changing → y_out constant, x_ready=0, no sample consumed. On y_ready=1: IDLE the next cycle, and the pending x_in is accepted.
- Coefficient timing:
  - Write coef[0]=7 during MAC → ignored; the result uses the old value.
  - Write coef[0]=7 on the same IDLE edge as a sample of 1 (history zero) → output 7.
- Reset mid-MAC after impulse step 2 → y_valid falls asynchronously. Reloading coef and replaying the impulse yields 1,2,3,4 again.
